line_driver: RTL and testbench

LINE_DRIVER -- requirements
Module: line_driver

---
 rtl/line_driver_pkg.sv | 22 ++
 rtl/word_sram.sv | 29 ++
 rtl/line_driver.sv | 140 ++++++++++++++
 tb/tb_line_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/line_driver_pkg.sv
// Shared constants for the line driver: state encoding, line geometry and a
// helper that picks one 32-bit word out of a 128-bit line.
package line_driver_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;

  // Plain constants (not an enum) so the encoding is visible to legacy tools.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;

  localparam logic [1:0] LastBeat = 2'(LINE_WORDS - 1);

  // Word n of a line lives at bits 32n+31:32n.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        idx);
    return line[int'(idx) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/word_sram.sv
// Single-port synchronous word RAM used as the line driver's backend.
// Read data appears one cycle after the address; a write also updates rdata_o
// with the old contents (read-before-write).
//   clk_i   : clock
//   addr_i  : word address (AW bits)
//   wdata_i : write data
//   we_i    : write enable
//   rdata_o : registered read data
module word_sram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          we_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/line_driver.sv
// Line driver: turns a single 128-bit line request into four 32-bit word
// accesses on a synchronous word memory with one-cycle read latency.
//   CLK, RST      : clock, synchronous active-high reset
//   REQ           : request strobe, only honoured when idle
//   ADDRESS       : line address
//   WDATA / RW    : line write data, direction (1 = write)
//   RDATA         : last completed line read
//   PENDING       : request in service
//   MEM_ADDRESS   : word address {line, beat}
//   MEM_WDATA     : word write data
//   MEM_WE        : word write enable
//   MEM_RDATA     : word read data (one cycle after its address)
module line_driver
  import line_driver_pkg::*;
#(
  parameter int unsigned ADDR_W = 26
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [LINE_W-1:0] WDATA,
  input  logic              RW,
  output logic [LINE_W-1:0] RDATA,
  output logic              PENDING,
  output logic [ADDR_W+1:0] MEM_ADDRESS,
  output logic [WORD_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  input  logic [WORD_W-1:0] MEM_RDATA
);

  localparam int unsigned ShadowW = LINE_W - WORD_W;

  logic [1:0]         state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic               tail_q, tail_d;
  logic [ADDR_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [ADDR_W+1:0]  mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic [ShadowW-1:0] shadow_q, shadow_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tail_d      = tail_q;
    line_d      = line_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    shadow_d    = shadow_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (REQ) begin
          line_d     = ADDRESS;
          wdata_d    = WDATA;
          beat_d     = 2'd0;
          tail_d     = 1'b0;
          // Beat 0 goes out on the acceptance edge itself.
          mem_addr_d = {ADDRESS, 2'd0};
          if (RW) begin
            state_d     = StWrite;
            mem_we_d    = 1'b1;
            mem_wdata_d = line_word(WDATA, 2'd0);
          end else begin
            state_d = StRead;
          end
        end
      end
      StWrite: begin
        if (beat_q == LastBeat) begin
          state_d = StIdle;
          beat_d  = 2'd0;
        end else begin
          beat_d      = beat_q + 2'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {line_q, beat_d};
          mem_wdata_d = line_word(wdata_q, beat_d);
        end
      end
      StRead: begin
        // MEM_RDATA carries the word addressed two edges ago; words shift in
        // from the top so word 0 ends up in the low bits.
        if (beat_q != 2'd0 || tail_q) begin
          shadow_d = {MEM_RDATA, shadow_q[ShadowW-1:WORD_W]};
        end
        if (tail_q) begin
          state_d = StIdle;
          beat_d  = 2'd0;
          tail_d  = 1'b0;
          rdata_d = {MEM_RDATA, shadow_q};
        end else if (beat_q == LastBeat) begin
          tail_d = 1'b1;
        end else begin
          beat_d     = beat_q + 2'd1;
          mem_addr_d = {line_q, beat_d};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      tail_q      <= 1'b0;
      line_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      shadow_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tail_q      <= tail_d;
      line_q      <= line_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      shadow_q    <= shadow_d;
      rdata_q     <= rdata_d;
    end
  end

  assign PENDING     = (state_q != StIdle);
  assign MEM_ADDRESS = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign MEM_WE      = mem_we_q;
  assign RDATA       = rdata_q;

endmodule

// File: tb/tb_line_driver.sv
module tb_line_driver;

  logic         clk;
  logic         rst;
  logic         req;
  logic [25:0]  address;
  logic [127:0] wdata;
  logic         rw;
  logic [127:0] rdata;
  logic         pending;
  logic [27:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic         mem_we;
  logic [31:0]  mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  line_driver #(.ADDR_W(26)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ        (req),
    .ADDRESS    (address),
    .WDATA      (wdata),
    .RW         (rw),
    .RDATA      (rdata),
    .PENDING    (pending),
    .MEM_ADDRESS(mem_address),
    .MEM_WDATA  (mem_wdata),
    .MEM_WE     (mem_we),
    .MEM_RDATA  (mem_rdata)
  );

  // 4K-word backend: line addresses alias on their low 10 bits.
  word_sram #(.AW(12), .DW(32)) u_sram (
    .clk_i  (clk),
    .addr_i (mem_address[11:0]),
    .wdata_i(mem_wdata),
    .we_i   (mem_we),
    .rdata_o(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Line-level reference model.
  logic [127:0] ref_mem [int];
  logic [25:0]  written [$];
  logic [127:0] model_rdata;
  logic [27:0]  model_maddr;
  logic [31:0]  model_mwdata;

  function automatic int key(input logic [25:0] a);
    return int'(a[9:0]);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Starts at a negedge with PENDING low; ends at the negedge where PENDING
  // is low again, so a following call issues its REQ back-to-back.
  // noise: 0 = none, 1 = random REQs while busy, 2 = REQ every busy cycle.
  task automatic do_txn(input logic op, input logic [25:0] a, input logic [127:0] d,
                        input int noise);
    logic [127:0] exp_rd;
    logic [31:0]  r;
    int           pend;
    int           exp_pend;
    exp_pend = op ? 4 : 5;
    exp_rd   = op ? model_rdata : (ref_mem.exists(key(a)) ? ref_mem[key(a)] : '0);
    req = 1'b1; rw = op; address = a; wdata = d;
    pend = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (!pending) break;
      pend++;
      if (pend <= 4) begin
        check("beat_addr", 128'(mem_address), 128'({a, 2'(pend - 1)}));
        check("beat_we", 128'(mem_we), 128'(op));
        if (op) check("beat_wdata", 128'(mem_wdata), 128'(d[(pend - 1) * 32 +: 32]));
      end else begin
        check("tail_we", 128'(mem_we), 128'(0));
      end
      check("rdata_hold", rdata, model_rdata);
      if (noise == 2 || (noise == 1 && $urandom_range(1) == 1)) begin
        r = $urandom;
        req = 1'b1; rw = r[31]; address = r[25:0]; wdata = rand128();
      end
    end
    check("pend_cycles", 128'(pend), 128'(exp_pend));
    if (op) begin
      ref_mem[key(a)] = d;
      written.push_back(a);
      model_mwdata = d[127:96];
    end else begin
      model_rdata = exp_rd;
    end
    model_maddr = {a, 2'd3};
    check("done_rdata", rdata, model_rdata);
    check("idle_we", 128'(mem_we), 128'(0));
    check("idle_addr", 128'(mem_address), 128'(model_maddr));
    check("idle_wdata", 128'(mem_wdata), 128'(model_mwdata));
  endtask

  typedef struct {
    logic         op;
    logic [25:0]  addr;
    logic [127:0] data;
    logic [127:0] exp_rdata;
    logic [27:0]  exp_last_addr;
  } vec_t;

  localparam logic [127:0] L1   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] OLD  = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
  localparam logic [127:0] NEW  = 128'h0000000D_0000000C_0000000B_0000000A;

  vec_t vecs [6];

  initial begin
    logic [31:0] r;
    logic [25:0] a;

    vecs[0] = '{1'b1, 26'h0000ABC, L1, '0, 28'h0002AF3};
    vecs[1] = '{1'b0, 26'h0000ABC, '0, L1, 28'h0002AF3};
    vecs[2] = '{1'b1, 26'h3FFFFFF, '1, L1, 28'hFFFFFFF};
    vecs[3] = '{1'b0, 26'h3FFFFFF, '0, '1, 28'hFFFFFFF};
    vecs[4] = '{1'b1, 26'h0000000, '0, '1, 28'h0000003};
    vecs[5] = '{1'b0, 26'h0000000, '0, '0, 28'h0000003};

    rst = 1'b1; req = 1'b0; rw = 1'b0; address = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_pending", 128'(pending), 128'(0));
    check("rst_we", 128'(mem_we), 128'(0));
    check("rst_addr", 128'(mem_address), 128'(0));
    check("rst_wdata", 128'(mem_wdata), 128'(0));
    check("rst_rdata", rdata, '0);
    rst = 1'b0;
    model_rdata = '0; model_maddr = '0; model_mwdata = '0;

    // Directed line transfers, including the top-of-range address.
    foreach (vecs[i]) begin
      do_txn(vecs[i].op, vecs[i].addr, vecs[i].data, 0);
      check("vec_rdata", rdata, vecs[i].exp_rdata);
      check("vec_last_addr", 128'(mem_address), 128'(vecs[i].exp_last_addr));
    end

    // REQ held every busy cycle of a read, then an immediate write.
    do_txn(1'b0, 26'h0000ABC, '0, 2);
    do_txn(1'b1, 26'h0000155, OLD, 0);
    do_txn(1'b0, 26'h0000ABC, '0, 0);

    // Reset on the edge that would issue beat 2 of a write.
    req = 1'b1; rw = 1'b1; address = 26'h0000155; wdata = NEW;
    @(negedge clk);
    req = 1'b0;
    check("abort_b0_we", 128'(mem_we), 128'(1));
    @(negedge clk);
    check("abort_b1_addr", 128'(mem_address), 128'({26'h0000155, 2'd1}));
    rst = 1'b1; req = 1'b1; rw = 1'b0; address = 26'h0000ABC;
    @(negedge clk);
    check("abort_pending", 128'(pending), 128'(0));
    check("abort_we", 128'(mem_we), 128'(0));
    check("abort_addr", 128'(mem_address), 128'(0));
    check("abort_wdata", 128'(mem_wdata), 128'(0));
    check("abort_rdata", rdata, '0);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("abort_req_ignored", 128'(pending), 128'(0));
    check("abort_no_we", 128'(mem_we), 128'(0));
    ref_mem[key(26'h0000155)] = {OLD[127:64], NEW[63:0]};
    model_rdata = '0; model_maddr = '0; model_mwdata = '0;
    do_txn(1'b0, 26'h0000155, '0, 0);
    check("abort_merged", rdata, {OLD[127:64], NEW[63:0]});

    // Randomized traffic against the line model.
    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      if (r[0]) begin
        do_txn(1'b1, r[31:6], rand128(), int'(r[1]));
      end else begin
        a = written[$urandom_range(written.size() - 1)];
        do_txn(1'b0, a, rand128(), int'(r[1]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
